// File: rtl/mmio_irq_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
// Holds the source index enum, register addresses, vector base and FSM state enum.
package gameman_irq_pkg;

    typedef enum logic [2:0] {
        VBLANK = 3'd0,
        STAT   = 3'd1,
        TIMER  = 3'd2,
        SERIAL = 3'd3,
        JOYPAD = 3'd4
    } irq_idx_e;

    localparam logic [15:0] IRQ_IF_ADDR  = 16'hFF0F;
    localparam logic [15:0] IRQ_IE_ADDR  = 16'hFFFF;
    localparam logic [7:0]  IRQ_VEC_BASE = 8'h40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } irq_state_e;

    function automatic logic [7:0] irq_vec(input logic [2:0] idx);
        return IRQ_VEC_BASE + {2'b00, idx, 3'b000};
    endfunction

    // Write-enable run counter: stops at 2 so a held write commits only once.
    function automatic logic [1:0] we_cnt_next(input logic [1:0] cnt);
        return (cnt == 2'd2) ? cnt : cnt + 2'd1;
    endfunction

endpackage

// File: rtl/mmio_irq_ctrl_if.sv
// Shared MMIO bus between the CPU side (master) and register slaves.
// A write is requested by holding write_enable with a stable addr_select/write_value;
// the slave takes it after two consecutive cycles, reads are combinational on addr_select.
interface mem_if;
    logic [15:0] addr_select;
    logic        write_enable;
    logic [7:0]  write_value;
    logic [7:0]  read_out;

    modport master (
        output addr_select,
        output write_enable,
        output write_value,
        input  read_out
    );

    modport slave (
        input  addr_select,
        input  write_enable,
        input  write_value,
        output read_out
    );
endinterface

// File: rtl/mmio_irq_ctrl_prio_enc.sv
// Fixed-priority encoder over the pending interrupt bits.
// Lowest set index wins, so vblank has the highest priority.
module irq_prio_enc
    import gameman_irq_pkg::*;
(
    input  logic [4:0] pending,
    output logic       valid,
    output logic [2:0] idx
);

    always_comb begin
        valid = |pending;
        idx   = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pending[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/mmio_irq_ctrl.sv
// Interrupt controller: IF/IE registers on the MMIO bus, priority selection and CPU dispatch.
// Optional build macro IRQ_DISPATCH_CANCEL_EN re-evaluates the dispatched source while in REQ.
module mmio_irq_ctrl
    import gameman_irq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    mem_if.slave       req,
    input  logic [4:0] irq_src,
    input  logic       ime,
    input  logic       irq_ack,
    output logic       irq_req,
    output logic [7:0] irq_vector,
    output logic       irq_wake
);

    logic [4:0] if_q;
    logic [4:0] if_d;
    logic [7:0] ie_q;
    logic [1:0] we_cnt_if;
    logic [1:0] we_cnt_ie;
    logic       hit_if;
    logic       hit_ie;
    logic       commit_if;
    logic       commit_ie;

    irq_state_e state_q;
    irq_state_e state_d;
    logic [2:0] idx_q;
    logic [2:0] idx_d;
    logic       idx_valid_q;
    logic       idx_valid_d;
    logic [7:0] vec_d;

    logic [4:0] pending;
    logic       enc_valid;
    logic [2:0] enc_idx;
    logic       ack_clear;

    assign hit_if    = req.write_enable && (req.addr_select == IRQ_IF_ADDR);
    assign hit_ie    = req.write_enable && (req.addr_select == IRQ_IE_ADDR);
    assign commit_if = hit_if && (we_cnt_if == 2'd1);
    assign commit_ie = hit_ie && (we_cnt_ie == 2'd1);

    assign pending   = if_q & ie_q[4:0];
    assign irq_wake  = |pending;
    assign irq_req   = (state_q == REQ);
    assign ack_clear = (state_q == REQ) && irq_ack && idx_valid_q;

    irq_prio_enc u_prio_enc (
        .pending (pending),
        .valid   (enc_valid),
        .idx     (enc_idx)
    );

    always_comb begin
        req.read_out = 8'haa;
        case (req.addr_select)
            IRQ_IF_ADDR: req.read_out = {3'b111, if_q};
            IRQ_IE_ADDR: req.read_out = ie_q;
            default:     req.read_out = 8'haa;
        endcase
    end

    // Write first, then ack clear, then new strobes so a set always wins.
    always_comb begin
        if_d = commit_if ? req.write_value[4:0] : if_q;
        if (ack_clear) if_d[idx_q] = 1'b0;
        if_d = if_d | irq_src;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_q      <= '0;
            ie_q      <= '0;
            we_cnt_if <= '0;
            we_cnt_ie <= '0;
        end else begin
            if_q      <= if_d;
            we_cnt_if <= hit_if ? we_cnt_next(we_cnt_if) : 2'd0;
            we_cnt_ie <= hit_ie ? we_cnt_next(we_cnt_ie) : 2'd0;
            if (commit_ie) ie_q <= req.write_value;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        idx_valid_d = idx_valid_q;
        vec_d       = irq_vector;
        case (state_q)
            IDLE: begin
                if (ime && enc_valid) begin
                    state_d     = REQ;
                    idx_d       = enc_idx;
                    idx_valid_d = 1'b1;
                    vec_d       = irq_vec(enc_idx);
                end
            end
            REQ: begin
`ifdef IRQ_DISPATCH_CANCEL_EN
                idx_d       = enc_idx;
                idx_valid_d = enc_valid;
                vec_d       = enc_valid ? irq_vec(enc_idx) : 8'h00;
`else
                idx_d       = idx_q;
                idx_valid_d = idx_valid_q;
`endif
                // ime dropping here does not withdraw the request.
                if (irq_ack) state_d = HOLD;
            end
            HOLD: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            irq_vector  <= 8'h00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            idx_valid_q <= idx_valid_d;
            irq_vector  <= vec_d;
        end
    end

endmodule

// File: tb/tb_mmio_irq_ctrl.sv
// Self-checking bench for mmio_irq_ctrl: vector table, directed corner sequences,
// and randomized traffic compared every cycle against a behavioural model.
module tb_mmio_irq_ctrl;
  import gameman_irq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [4:0] irq_src;
  logic       ime;
  logic       irq_ack;
  logic       irq_req;
  logic [7:0] irq_vector;
  logic       irq_wake;

  mem_if bus();

  mmio_irq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (bus),
    .irq_src    (irq_src),
    .ime        (ime),
    .irq_ack    (irq_ack),
    .irq_req    (irq_req),
    .irq_vector (irq_vector),
    .irq_wake   (irq_wake)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  logic [7:0] exp_q[$];

  // behavioural model state
  logic [4:0]  m_if;
  logic [7:0]  m_ie;
  bit          m_req;
  bit          m_hold;
  int          m_idx;
  bit          m_valid;
  logic [7:0]  m_vec;
  int          run_len;
  logic [15:0] run_addr;

  typedef struct {
    logic [7:0] ie;
    logic [4:0] src;
    logic [7:0] exp_if;
    logic       exp_wake;
    logic       exp_req;
    logic [7:0] exp_vec;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  function automatic int lowest(input logic [4:0] p);
    int v;
    int lsb;
    v   = int'(p);
    lsb = v & -v;
    return $clog2(lsb);
  endfunction

  task automatic model_reset();
    m_if = '0; m_ie = '0; m_req = 0; m_hold = 0;
    m_idx = 0; m_valid = 0; m_vec = 8'h00; run_len = 0; run_addr = '0;
  endtask

  task automatic model_edge();
    logic [4:0] pend;
    logic [4:0] nif;
    logic [7:0] nie;
    bit commit;
    pend = m_if & m_ie[4:0];
    nif  = m_if;
    nie  = m_ie;
    if (bus.write_enable) begin
      if (run_len > 0 && run_addr == bus.addr_select) run_len++;
      else begin
        run_len  = 1;
        run_addr = bus.addr_select;
      end
    end else begin
      run_len = 0;
    end
    commit = (run_len == 2);
    if (commit && bus.addr_select == IRQ_IF_ADDR) nif = bus.write_value[4:0];
    if (commit && bus.addr_select == IRQ_IE_ADDR) nie = bus.write_value;
    if (m_req && irq_ack && m_valid) nif[m_idx] = 1'b0;
    nif = nif | irq_src;
    if (m_req) begin
`ifdef IRQ_DISPATCH_CANCEL_EN
      m_valid = (pend != 0);
      m_idx   = m_valid ? lowest(pend) : 0;
      m_vec   = m_valid ? 8'(64 + 8 * m_idx) : 8'h00;
`endif
      if (irq_ack) begin
        m_req  = 0;
        m_hold = 1;
      end
    end else if (m_hold) begin
      m_hold = 0;
    end else if (ime && pend != 0) begin
      m_req   = 1;
      m_idx   = lowest(pend);
      m_valid = 1;
      m_vec   = 8'(64 + 8 * m_idx);
    end
    m_if = nif;
    m_ie = nie;
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] exp_rd;
    check({tag, ".req"}, 8'(irq_req), 8'(m_req));
    check({tag, ".wake"}, 8'(irq_wake), 8'(|(m_if & m_ie[4:0])));
    if (m_req) check({tag, ".vec"}, irq_vector, m_vec);
    if (bus.addr_select == IRQ_IF_ADDR) exp_rd = {3'b111, m_if};
    else if (bus.addr_select == IRQ_IE_ADDR) exp_rd = m_ie;
    else exp_rd = 8'haa;
    check({tag, ".rd"}, bus.read_out, exp_rd);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.write_enable = 1'b0;
    irq_src = '0;
    irq_ack = 1'b0;
    ime = 1'b0;
    #1;
    model_reset();
    check("rst.req", 8'(irq_req), 8'h00);
    check("rst.vec", irq_vector, 8'h00);
    check("rst.wake", 8'(irq_wake), 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e, input string name);
    bus.addr_select  = a;
    bus.write_enable = 1'b0;
    #1;
    check(name, bus.read_out, e);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] v);
    bus.addr_select  = a;
    bus.write_value  = v;
    bus.write_enable = 1'b1;
    tick();
    tick();
    bus.write_enable = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1;
    irq_src = '0;
    ime = 1'b0;
    irq_ack = 1'b0;
    bus.addr_select = '0;
    bus.write_enable = 1'b0;
    bus.write_value = '0;
    model_reset();
    #2;

    tbl[0] = '{8'h1F, 5'h04, 8'hE4, 1'b1, 1'b1, 8'h50};
    tbl[1] = '{8'h1F, 5'h1F, 8'hFF, 1'b1, 1'b1, 8'h40};
    tbl[2] = '{8'h1F, 5'h18, 8'hF8, 1'b1, 1'b1, 8'h58};
    tbl[3] = '{8'h10, 5'h0F, 8'hEF, 1'b0, 1'b0, 8'h00};
    tbl[4] = '{8'h1C, 5'h13, 8'hF3, 1'b1, 1'b1, 8'h60};
    tbl[5] = '{8'h00, 5'h1F, 8'hFF, 1'b0, 1'b0, 8'h00};
    tbl[6] = '{8'hE2, 5'h03, 8'hE3, 1'b1, 1'b1, 8'h48};

    // reset values and reads
    do_reset();
    rd(IRQ_IF_ADDR, 8'hE0, "rst.if");
    rd(IRQ_IE_ADDR, 8'h00, "rst.ie");
    rd(16'hFF10, 8'haa, "rst.other");

    // vector table
    for (int i = 0; i < 7; i++) begin
      do_reset();
      ime = 1'b1;
      wr(IRQ_IE_ADDR, tbl[i].ie);
      irq_src = tbl[i].src;
      tick();
      irq_src = '0;
      rd(IRQ_IF_ADDR, tbl[i].exp_if, "tbl.if");
      check("tbl.wake", 8'(irq_wake), 8'(tbl[i].exp_wake));
      tick();
      check("tbl.req", 8'(irq_req), 8'(tbl[i].exp_req));
      if (tbl[i].exp_req) check("tbl.vec", irq_vector, tbl[i].exp_vec);
    end

    // timer dispatch with latency, ack and hold
    do_reset();
    ime = 1'b1;
    wr(IRQ_IE_ADDR, 8'h1F);
    rd(IRQ_IE_ADDR, 8'h1F, "tmr.ie");
    irq_src = 5'h04;
    tick();
    irq_src = '0;
    rd(IRQ_IF_ADDR, 8'hE4, "tmr.if");
    check("tmr.wake", 8'(irq_wake), 8'h01);
    check("tmr.req_n1", 8'(irq_req), 8'h00);
    tick();
    check("tmr.req", 8'(irq_req), 8'h01);
    check("tmr.vec", irq_vector, 8'h50);
    tick();
    check("tmr.vec_stable", irq_vector, 8'h50);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("tmr.hold", 8'(irq_req), 8'h00);
    rd(IRQ_IF_ADDR, 8'hE0, "tmr.if_clr");
    tick();
    check("tmr.idle", 8'(irq_req), 8'h00);

    // multiple sources served in priority order
    do_reset();
    ime = 1'b1;
    wr(IRQ_IE_ADDR, 8'h1F);
    exp_q = {8'h40, 8'h50, 8'h60};
    irq_src = 5'b10101;
    tick();
    irq_src = '0;
    for (int k = 0; k < 3; k++) begin
      int w;
      w = 0;
      while (!irq_req && w < 8) begin
        tick();
        w++;
      end
      check("prio.req", 8'(irq_req), 8'h01);
      check("prio.vec", irq_vector, exp_q.pop_front());
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
    end
    rd(IRQ_IF_ADDR, 8'hE0, "prio.if");

    // write and strobe in the same cycle: set wins
    do_reset();
    irq_src = 5'h04;
    tick();
    irq_src = '0;
    bus.addr_select = IRQ_IF_ADDR;
    bus.write_value = 8'h00;
    bus.write_enable = 1'b1;
    tick();
    irq_src = 5'h01;
    tick();
    irq_src = '0;
    bus.write_enable = 1'b0;
    rd(IRQ_IF_ADDR, 8'hE1, "wrset.if");

    // ack and new strobe of the same bit
    do_reset();
    ime = 1'b1;
    wr(IRQ_IE_ADDR, 8'h1F);
    irq_src = 5'h04;
    tick();
    irq_src = '0;
    tick();
    check("ackset.req", 8'(irq_req), 8'h01);
    irq_ack = 1'b1;
    irq_src = 5'h04;
    tick();
    irq_ack = 1'b0;
    irq_src = '0;
    rd(IRQ_IF_ADDR, 8'hE4, "ackset.if");
    check("ackset.hold", 8'(irq_req), 8'h00);

    // wake without ime, then dispatch when ime rises
    do_reset();
    wr(IRQ_IE_ADDR, 8'h01);
    irq_src = 5'h01;
    tick();
    irq_src = '0;
    check("wake.wake", 8'(irq_wake), 8'h01);
    tick();
    tick();
    check("wake.noreq", 8'(irq_req), 8'h00);
    ime = 1'b1;
    tick();
    check("wake.req", 8'(irq_req), 8'h01);
    check("wake.vec", irq_vector, 8'h40);

    // IF cleared by a write while in REQ
    do_reset();
    ime = 1'b1;
    wr(IRQ_IE_ADDR, 8'h1F);
    irq_src = 5'h04;
    tick();
    irq_src = '0;
    tick();
    check("cancel.vec0", irq_vector, 8'h50);
    wr(IRQ_IF_ADDR, 8'h00);
    tick();
    check("cancel.req", 8'(irq_req), 8'h01);
`ifdef IRQ_DISPATCH_CANCEL_EN
    check("cancel.vec", irq_vector, 8'h00);
`else
    check("cancel.vec", irq_vector, 8'h50);
`endif
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    rd(IRQ_IF_ADDR, 8'hE0, "cancel.if");

    // held write commits once; single-cycle and split writes do not commit
    do_reset();
    bus.addr_select = IRQ_IF_ADDR;
    bus.write_value = 8'h00;
    bus.write_enable = 1'b1;
    tick();
    tick();
    irq_src = 5'h04;
    tick();
    irq_src = '0;
    tick();
    bus.write_enable = 1'b0;
    rd(IRQ_IF_ADDR, 8'hE4, "sat.if");
    bus.addr_select = IRQ_IE_ADDR;
    bus.write_value = 8'hFF;
    bus.write_enable = 1'b1;
    tick();
    bus.write_enable = 1'b0;
    rd(IRQ_IE_ADDR, 8'h00, "single.ie");
    bus.addr_select = IRQ_IF_ADDR;
    bus.write_value = 8'h5A;
    bus.write_enable = 1'b1;
    tick();
    bus.addr_select = IRQ_IE_ADDR;
    tick();
    tick();
    bus.write_enable = 1'b0;
    rd(IRQ_IE_ADDR, 8'h5A, "split.ie");
    rd(IRQ_IF_ADDR, 8'hE4, "split.if");

    // reset mid-dispatch drops the request at once
    do_reset();
    ime = 1'b1;
    wr(IRQ_IE_ADDR, 8'h1F);
    irq_src = 5'h08;
    tick();
    irq_src = '0;
    tick();
    check("midrst.req_pre", 8'(irq_req), 8'h01);
    check("midrst.vec_pre", irq_vector, 8'h58);
    do_reset();
    rd(IRQ_IF_ADDR, 8'hE0, "midrst.if");
    rd(IRQ_IE_ADDR, 8'h00, "midrst.ie");

    // randomized traffic against the model
    do_reset();
    ime = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.addr_select = IRQ_IF_ADDR;
          1: bus.addr_select = IRQ_IE_ADDR;
          2: bus.addr_select = 16'hFF10;
          default: bus.addr_select = 16'($urandom);
        endcase
      end
      bus.write_enable = ($urandom_range(0, 2) == 0);
      bus.write_value  = 8'($urandom);
      irq_src = 5'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) ime = ~ime;
      irq_ack = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
